debounce_sync: RTL and testbench

- Upstream conditioning stage for the latch / flip-flop capture block.
- Takes an asynchronous, bouncy raw input (switch or external pin) and synchronises it into the `clk` domain.
- Qualifies each level change over a programmable number of stable cycles, then drives a clean level plus single-cycle rise/fall strobes.
- `d_clean` is the signal wired to the downstream stage's `d` input.

---
 rtl/debounce_pkg.sv | 30 +++
 rtl/sync_chain.sv | 35 +++
 rtl/debounce_sync.sv | 160 ++++++++++++++++
 tb/tb_debounce_sync.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// ----------------------------------------------------------------------------
// debounce_pkg
// Shared types and default constants for the debounce_sync conditioning stage.
//   debounce_state_e      : qualification FSM states (2-bit encoding)
//   DEB_SYNC_STAGES_DEF   : default synchroniser depth
//   DEB_STABLE_CYCLES_DEF : default number of stable samples to accept a level
//   deb_cnt_w()           : width of the qualification counter, minimum 1 bit
// ----------------------------------------------------------------------------
package debounce_pkg;

    localparam int unsigned DEB_SYNC_STAGES_DEF   = 2;
    localparam int unsigned DEB_STABLE_CYCLES_DEF = 8;

    // Encoding keeps bit 1 equal to the accepted level and bit 0 set while
    // a candidate level change is being qualified.
    typedef enum logic [1:0] {
        IDLE_LOW  = 2'b00,
        QUAL_HIGH = 2'b01,
        IDLE_HIGH = 2'b10,
        QUAL_LOW  = 2'b11
    } debounce_state_e;

    // The counter only has to hold 0..stable_cycles-1.
    function automatic int unsigned deb_cnt_w(input int unsigned stable_cycles);
        int unsigned w;
        w = $clog2(stable_cycles);
        return (w < 1) ? 1 : w;
    endfunction

endpackage : debounce_pkg

// File: rtl/sync_chain.sv
// ----------------------------------------------------------------------------
// sync_chain
// Plain multi-flop synchroniser bringing an asynchronous level into the clk
// domain. No logic is placed between the stages so each flop gets a full
// period to resolve metastability.
//   clk   : system clock, rising-edge active
//   rst_n : asynchronous active-low reset, clears every stage
//   d_in  : asynchronous input
//   d_out : synchronised output (last stage)
// ----------------------------------------------------------------------------
module sync_chain
    import debounce_pkg::*;
#(
    parameter int unsigned STAGES = DEB_SYNC_STAGES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_in,
    output logic d_out
);

    logic [STAGES-1:0] stages;

    // Shift the raw level through the chain; stage 0 is the capture flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stages <= '0;
        end else begin
            stages <= {stages[STAGES-2:0], d_in};
        end
    end

    assign d_out = stages[STAGES-1];

endmodule : sync_chain

// File: rtl/debounce_sync.sv
// ----------------------------------------------------------------------------
// debounce_sync
// Synchronises a bouncy asynchronous input into the clk domain, qualifies each
// level change over STABLE_CYCLES identical samples, and drives a clean level
// with single-cycle rise/fall strobes. d_clean feeds the downstream capture
// stage's d input.
//
// Build option: define DEBOUNCE_EVT_COUNT_EN to add the evt_count port, a
// saturating count of accepted rising events.
//
// Ports:
//   clk       : system clock, rising-edge active
//   rst_n     : asynchronous active-low reset
//   d_raw     : raw asynchronous input
//   d_clean   : debounced, synchronised level
//   rise      : one-cycle strobe when d_clean goes 0->1
//   fall      : one-cycle strobe when d_clean goes 1->0
//   busy      : high while a candidate level change is being qualified
//   evt_count : saturating rising-event count (DEBOUNCE_EVT_COUNT_EN only)
// ----------------------------------------------------------------------------
module debounce_sync
    import debounce_pkg::*;
#(
    parameter int unsigned SYNC_STAGES   = DEB_SYNC_STAGES_DEF,
    parameter int unsigned STABLE_CYCLES = DEB_STABLE_CYCLES_DEF,
    parameter int unsigned EVT_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             d_raw,
    output logic             d_clean,
    output logic             rise,
    output logic             fall,
    output logic             busy
`ifdef DEBOUNCE_EVT_COUNT_EN
    ,
    output logic [EVT_W-1:0] evt_count
`endif
);

    localparam int unsigned CNT_W = deb_cnt_w(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    // Reject illegal parameterisations at elaboration time.
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync_stages
        $error("debounce_sync: SYNC_STAGES must be in 2..4");
    end
    if (STABLE_CYCLES < 2 || STABLE_CYCLES > 256) begin : g_bad_stable_cycles
        $error("debounce_sync: STABLE_CYCLES must be in 2..256");
    end
    if (EVT_W < 1) begin : g_bad_evt_w
        $error("debounce_sync: EVT_W must be at least 1");
    end

    logic            d_sync;
    debounce_state_e state;
    logic [CNT_W-1:0] cnt;

    // Bring d_raw into the clk domain.
    sync_chain #(
        .STAGES (SYNC_STAGES)
    ) u_sync_chain (
        .clk   (clk),
        .rst_n (rst_n),
        .d_in  (d_raw),
        .d_out (d_sync)
    );

    // Qualification FSM. cnt holds the number of consecutive candidate
    // samples seen so far; the sample arriving when cnt==CNT_MAX is the
    // STABLE_CYCLES-th and commits the new level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE_LOW;
            cnt     <= '0;
            d_clean <= 1'b0;
            rise    <= 1'b0;
            fall    <= 1'b0;
            busy    <= 1'b0;
        end else begin
            // Strobes default low so they last exactly one cycle.
            rise <= 1'b0;
            fall <= 1'b0;

            case (state)
                IDLE_LOW: begin
                    if (d_sync) begin
                        state <= QUAL_HIGH;
                        cnt   <= CNT_W'(1);
                        busy  <= 1'b1;
                    end else begin
                        cnt <= '0;
                    end
                end

                QUAL_HIGH: begin
                    if (!d_sync) begin
                        // Glitch: fall back without touching d_clean.
                        state <= IDLE_LOW;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else if (cnt == CNT_MAX) begin
                        state   <= IDLE_HIGH;
                        cnt     <= '0;
                        busy    <= 1'b0;
                        d_clean <= 1'b1;
                        rise    <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                IDLE_HIGH: begin
                    if (!d_sync) begin
                        state <= QUAL_LOW;
                        cnt   <= CNT_W'(1);
                        busy  <= 1'b1;
                    end else begin
                        cnt <= '0;
                    end
                end

                QUAL_LOW: begin
                    if (d_sync) begin
                        state <= IDLE_HIGH;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else if (cnt == CNT_MAX) begin
                        state   <= IDLE_LOW;
                        cnt     <= '0;
                        busy    <= 1'b0;
                        d_clean <= 1'b0;
                        fall    <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                default: begin
                    state   <= IDLE_LOW;
                    cnt     <= '0;
                    busy    <= 1'b0;
                    d_clean <= 1'b0;
                end
            endcase
        end
    end

`ifdef DEBOUNCE_EVT_COUNT_EN
    // Saturating count of accepted rising events.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evt_count <= '0;
        end else if (rise && (evt_count != '1)) begin
            evt_count <= evt_count + EVT_W'(1);
        end
    end
`endif

endmodule : debounce_sync

// File: tb/tb_debounce_sync.sv
// ----------------------------------------------------------------------------
// tb_debounce_sync
// Self-checking bench for debounce_sync with default parameters and a 20 ns
// clock. A cycle model predicts the registered outputs at every rising edge;
// predictions are queued and compared on the following falling edge. A table
// of level/duration segments and directed sequences cover reset, glitches,
// bounce and reset during qualification.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_debounce_sync;
    import debounce_pkg::*;

    localparam int SYNC   = 2;
    localparam int STABLE = 8;
    localparam int EVT_W  = 8;
    localparam int EVT_MAX = (1 << EVT_W) - 1;

    logic clk;
    logic rst_n;
    logic d_raw;
    logic d_clean;
    logic rise;
    logic fall;
    logic busy;
`ifdef DEBOUNCE_EVT_COUNT_EN
    logic [EVT_W-1:0] evt_count;
`endif

    debounce_sync #(
        .SYNC_STAGES   (SYNC),
        .STABLE_CYCLES (STABLE),
        .EVT_W         (EVT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .d_raw     (d_raw),
        .d_clean   (d_clean),
        .rise      (rise),
        .fall      (fall),
        .busy      (busy)
`ifdef DEBOUNCE_EVT_COUNT_EN
        ,
        .evt_count (evt_count)
`endif
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model + scoreboard ----------------
    typedef struct {
        logic [3:0] flags;   // {d_clean, rise, fall, busy}
        int         evt;
    } exp_t;

    exp_t      sb_q[$];
    logic [SYNC-1:0] m_sync;
    logic      m_ds;
    logic      m_clean;
    logic      m_rise;
    logic      m_fall;
    int        m_run;    // consecutive samples disagreeing with m_clean
    int        m_evt;
    int        sb_cycle = 0;

    task automatic model_step();
        exp_t e;
        if (!rst_n) begin
            m_sync  = '0;
            m_clean = 1'b0;
            m_rise  = 1'b0;
            m_fall  = 1'b0;
            m_run   = 0;
            m_evt   = 0;
            sb_q.delete();
        end else begin
            if (m_rise && m_evt < EVT_MAX) m_evt++;
            m_ds   = m_sync[SYNC-1];
            m_sync = {m_sync[SYNC-2:0], d_raw};
            m_rise = 1'b0;
            m_fall = 1'b0;
            if (m_ds !== m_clean) begin
                m_run++;
                if (m_run == STABLE) begin
                    m_clean = m_ds;
                    if (m_ds) m_rise = 1'b1;
                    else      m_fall = 1'b1;
                    m_run = 0;
                end
            end else begin
                m_run = 0;
            end
            e.flags = {m_clean, m_rise, m_fall, (m_run != 0)};
            e.evt   = m_evt;
            sb_q.push_back(e);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            model_step();
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && sb_q.size() > 0) begin
                e = sb_q.pop_front();
                sb_cycle++;
                checks++;
                if ({d_clean, rise, fall, busy} !== e.flags) begin
                    errors++;
                    $display("FAIL sb_outputs cycle %0d: got {clean,rise,fall,busy}=%b expected %b (t=%0t)",
                             sb_cycle, {d_clean, rise, fall, busy}, e.flags, $time);
                end
`ifdef DEBOUNCE_EVT_COUNT_EN
                chk("sb_evt_count", 32'(evt_count), 32'(e.evt));
`endif
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    int seg_rises;
    int seg_falls;
    int seg_busy;

    // Drive one level for one clock and sample outputs just after the edge.
    task automatic cycle(input logic level);
        @(negedge clk);
        d_raw = level;
        @(posedge clk);
        #1;
        if (rise) seg_rises++;
        if (fall) seg_falls++;
        if (busy) seg_busy++;
    endtask

    task automatic clear_counts();
        seg_rises = 0;
        seg_falls = 0;
        seg_busy  = 0;
    endtask

    // Count 10 edges after a reset release with d_raw held high.
    task automatic requalify(input string tag);
        logic early;
        early = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk);
            #1;
            if (i < 10) early = early | d_clean | rise | fall;
        end
        chk({tag, "_early"}, 32'(early), 32'd0);
        chk({tag, "_clean10"}, 32'(d_clean), 32'd1);
        chk({tag, "_rise10"}, 32'(rise), 32'd1);
        @(posedge clk);
        #1;
        chk({tag, "_rise11"}, 32'(rise), 32'd0);
    endtask

    typedef struct {
        logic level;
        int   cycles;
        int   rises;
        int   falls;
        logic clean;
    } vec_t;

    vec_t vecs[8];
    int   bounce_dly[15];

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{1'b1, 12, 1, 0, 1'b1};   // clean accept high
        vecs[1] = '{1'b0,  5, 0, 0, 1'b1};   // short low glitch rejected
        vecs[2] = '{1'b1, 12, 0, 0, 1'b1};
        vecs[3] = '{1'b0, 12, 0, 1, 1'b0};   // clean accept low
        vecs[4] = '{1'b1,  7, 0, 0, 1'b0};   // one sample short of accept
        vecs[5] = '{1'b0, 12, 0, 0, 1'b0};
        vecs[6] = '{1'b1,  8, 0, 0, 1'b0};   // exactly STABLE samples, rise lands later
        vecs[7] = '{1'b0, 12, 1, 1, 1'b0};   // delayed rise, then fall
        bounce_dly = '{3, 4, 2, 3, 6, 3, 5, 3, 4, 5, 3, 6, 2, 4, 5};

        // 1: reset held with d_raw high, then release
        d_raw = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("t1_reset_outputs", 32'({d_clean, rise, fall, busy}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        requalify("t1");

        // 3: from IDLE_HIGH, hold low for 12 cycles
        clear_counts();
        for (int i = 1; i <= 12; i++) begin
            cycle(1'b0);
            if (i == 10) begin
                chk("t3_clean10", 32'(d_clean), 32'd0);
                chk("t3_fall10", 32'(fall), 32'd1);
            end
        end
        chk("t3_falls", 32'(seg_falls), 32'd1);
        chk("t3_rises", 32'(seg_rises), 32'd0);

        // 2: five-cycle high pulse from IDLE_LOW is rejected
        clear_counts();
        for (int i = 0; i < 5; i++) cycle(1'b1);
        for (int i = 0; i < 8; i++) cycle(1'b0);
        chk("t2_busy_cycles", 32'(seg_busy), 32'd5);
        chk("t2_strobes", 32'(seg_rises + seg_falls), 32'd0);
        chk("t2_clean", 32'(d_clean), 32'd0);
        chk("t2_state", 32'(dut.state), 32'(IDLE_LOW));

        // Table of level segments
        for (int v = 0; v < 8; v++) begin
            clear_counts();
            for (int c = 0; c < vecs[v].cycles; c++) cycle(vecs[v].level);
            chk($sformatf("vec%0d_rises", v), 32'(seg_rises), 32'(vecs[v].rises));
            chk($sformatf("vec%0d_falls", v), 32'(seg_falls), 32'(vecs[v].falls));
            chk($sformatf("vec%0d_clean", v), 32'(d_clean), 32'(vecs[v].clean));
        end

        // 4: sub-period bounce ending high
        clear_counts();
        @(negedge clk);
        d_raw = 1'b0;
        for (int i = 0; i < 15; i++) begin
            #(bounce_dly[i]);
            d_raw = ~d_raw;
        end
        for (int i = 0; i < 16; i++) cycle(1'b1);
        chk("t4_rises", 32'(seg_rises), 32'd1);
        chk("t4_clean", 32'(d_clean), 32'd1);

        // 5: reset during QUAL_HIGH with cnt=4
        for (int i = 0; i < 12; i++) cycle(1'b0);
        chk("t5_pre_clean", 32'(d_clean), 32'd0);
        clear_counts();
        for (int i = 0; i < 6; i++) cycle(1'b1);
        chk("t5_state_qual", 32'(dut.state), 32'(QUAL_HIGH));
        chk("t5_cnt4", 32'(dut.cnt), 32'd4);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_reset_outputs", 32'({d_clean, rise, fall, busy}), 32'd0);
        chk("t5_reset_cnt", 32'(dut.cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        chk("t5_no_rise", 32'(seg_rises), 32'd0);
        requalify("t5");

`ifdef DEBOUNCE_EVT_COUNT_EN
        // 6: saturating event counter; the reset in test 5 restarted it
        for (int p = 1; p <= 300; p++) begin
            for (int i = 0; i < 10; i++) cycle(1'b0);
            for (int i = 0; i < 10; i++) cycle(1'b1);
            for (int i = 0; i < 2; i++) cycle(1'b1);
            if (p == 254) chk("t6_evt_254", 32'(evt_count), 32'd255);
        end
        chk("t6_evt_sat", 32'(evt_count), 32'd255);
`endif

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_debounce_sync
